alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Program sequencer sitting directly upstream of the 8-bit ALU. Fetches 12-bit
//   instructions from a synchronous program ROM and decodes them, one ALU opcode
//   per instruction. Drives the ALU opcode/data_in pair for one cycle per instruction.
//   Resolves jumps from the ALU acc_zero/acc_overflow flags.
// PARAMETERS
//   DATA_WIDTH  8     width of alu_data / instruction operand
//   ADDR_WIDTH  8     program counter / ROM address width
//   NOP_OPCODE  4'hF  ALU opcode driven when no ALU action is wanted (hits ALU default)
// PORTS
//   clk           in   1           system clock; all logic on posedge
//   s_reset       in   1           synchronous active-high reset
//   start         in   1           1-cycle pulse: run program from address 0
//   busy          out  1           high from FETCH after start until HLT completes
//   done          out  1           1-cycle pulse when HLT executes
//   prog_en       out  1           ROM read enable
//   prog_addr     out  ADDR_WIDTH  ROM address (= pc)
//   prog_data     in   4+DATA_W    ROM word, valid 1 cycle after prog_en; [11:8] op, [7:0] operand
//   alu_opcode    out  4           to ALU opcode (sap1_header.vh ALU_* constants)
//   alu_data      out  DATA_WIDTH  to ALU data_in
//   acc_zero      in   1           from ALU
//   acc_overflow  in   1           from ALU
// BEHAVIOUR
//   Reset: state=IDLE, pc=0, ir=0. busy=0, done=0, prog_en=0, prog_addr=0.
//     alu_opcode=NOP_OPCODE, alu_data=0. Reset wins over every other event and
//     takes effect from any state, including mid-instruction.
//   FSM: IDLE -> FETCH -> DECODE -> EXEC -> FETCH ... ; HLT in EXEC -> IDLE.
//     IDLE: start=1 -> FETCH next cycle; else stay.
//     FETCH: prog_en=1, prog_addr=pc. Next state is DECODE.
//     DECODE: latch ir<=prog_data. Next state is EXEC.
//     EXEC: alu_opcode/alu_data driven combinationally from ir for exactly this cycle.
//       Update pc. Next state is FETCH, or IDLE for HLT.
//   Outside EXEC: alu_opcode=NOP_OPCODE, alu_data=0. Each instruction takes 3 cycles.
//   start is ignored while busy=1.
//   Instruction decode (ir[11:8]):
//     0 NOP: no ALU action.  1 LDA: ALU_REGA, alu_data=ir[7:0].
//     2 ADD  3 SUB  4 AND  5 OR  6 XOR  7 SHL(ALU_LSHIFT)  8 SHR(ALU_RSHIFT)
//     9 OUT  A CLR(ALU_RESET): alu_data=0.
//     B JMP: pc<=ir[ADDR_WIDTH-1:0].
//     C JZ: jump if acc_zero=1, else pc+1.
//     D JV: jump if acc_overflow=1, else pc+1.
//     E reserved: treated as NOP.
//     F HLT: done=1 for this EXEC cycle. busy drops the next cycle. pc holds.
//   Flags are sampled in EXEC of the branch. The prior ALU op completed >=2 cycles
//     earlier, so flags are settled; no extra wait state.
//   pc increment is modulo 2^ADDR_WIDTH: pc=max, non-jump -> pc=0.
//   busy=1 in FETCH/DECODE/EXEC; 0 in IDLE.
// TESTING
//   ROM{1_05,2_00,2_00,9_00,F_00}, start -> alu_opcode seq REGA(data 05),ADD,ADD,OUT,
//     1 EXEC cycle each, 3 cycles apart; done pulses 15 cycles after start sampled.
//   ROM{A_00,C_05,..,@05 F_00}, acc_zero=1 in EXEC of JZ -> next prog_addr=05, then done.
//   JV with acc_overflow=0 at addr 3 -> next prog_addr=04; repeat with 1 -> operand addr.
//   ROM{B_FF,..,@FF 0_00} -> fetch at FF, then prog_addr wraps to 00.
//   s_reset=1 during EXEC of ADD -> next cycle IDLE, busy=0, alu_opcode=NOP_OPCODE, pc=0.
//   start re-pulsed while busy -> ignored; pc sequence unchanged, single done pulse.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Program sequencer feeding the 8-bit ALU. It fetches 12-bit instructions from a
// synchronous program ROM, decodes one ALU opcode per instruction, drives the
// ALU opcode/data pair for a single EXEC cycle, and resolves conditional jumps
// from the ALU zero/overflow flags. Every instruction takes three cycles:
// FETCH (ROM read), DECODE (capture word), EXEC (drive ALU, update pc).
module alu_sequencer #(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [3:0] NOP_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  prog_en,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH+3:0] prog_data,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  acc_zero,
  input  logic                  acc_overflow
);

  localparam int IR_W = DATA_WIDTH + 4;

  // ALU opcode encodings understood by the downstream ALU
  localparam logic [3:0] ALU_RESET  = 4'h0;
  localparam logic [3:0] ALU_REGA   = 4'h1;
  localparam logic [3:0] ALU_ADD    = 4'h2;
  localparam logic [3:0] ALU_SUB    = 4'h3;
  localparam logic [3:0] ALU_AND    = 4'h4;
  localparam logic [3:0] ALU_OR     = 4'h5;
  localparam logic [3:0] ALU_XOR    = 4'h6;
  localparam logic [3:0] ALU_LSHIFT = 4'h7;
  localparam logic [3:0] ALU_RSHIFT = 4'h8;
  localparam logic [3:0] ALU_OUT    = 4'h9;

  // Instruction opcodes held in ir[IR_W-1:DATA_WIDTH]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_CLR = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JV  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [IR_W-1:0]       ir, ir_nxt;
  logic [3:0]            ir_op;
  logic [DATA_WIDTH-1:0] ir_operand;
  logic [ADDR_WIDTH-1:0] jmp_tgt;
  logic                  is_halt;

  assign ir_op      = ir[IR_W-1:DATA_WIDTH];
  assign ir_operand = ir[DATA_WIDTH-1:0];
  assign is_halt    = (ir_op == OP_HLT);

  // Jump target: operand resized to the pc width (zero-extend or truncate)
  always_comb begin
    jmp_tgt = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (i < DATA_WIDTH) jmp_tgt[i] = ir_operand[i];
    end
  end

  // State, program counter and instruction register; reset wins over everything
  always_ff @(posedge clk) begin
    if (s_reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state logic and the control outputs that depend only on state
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    busy      = 1'b0;
    prog_en   = 1'b0;
    prog_addr = pc;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        prog_en   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        busy      = 1'b1;
        ir_nxt    = prog_data;
        state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = is_halt ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction execute: ALU drive, done pulse and pc update, active only in EXEC
  always_comb begin
    alu_opcode = NOP_OPCODE;
    alu_data   = '0;
    done       = 1'b0;
    pc_nxt     = pc;
    if (state == EXEC) begin
      // Increment wraps naturally at 2^ADDR_WIDTH
      pc_nxt = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      case (ir_op)
        OP_LDA: begin alu_opcode = ALU_REGA;   alu_data = ir_operand; end
        OP_ADD: begin alu_opcode = ALU_ADD;    alu_data = ir_operand; end
        OP_SUB: begin alu_opcode = ALU_SUB;    alu_data = ir_operand; end
        OP_AND: begin alu_opcode = ALU_AND;    alu_data = ir_operand; end
        OP_OR:  begin alu_opcode = ALU_OR;     alu_data = ir_operand; end
        OP_XOR: begin alu_opcode = ALU_XOR;    alu_data = ir_operand; end
        OP_SHL: begin alu_opcode = ALU_LSHIFT; alu_data = ir_operand; end
        OP_SHR: begin alu_opcode = ALU_RSHIFT; alu_data = ir_operand; end
        OP_OUT: begin alu_opcode = ALU_OUT;    alu_data = ir_operand; end
        OP_CLR: alu_opcode = ALU_RESET;
        OP_JMP: pc_nxt = jmp_tgt;
        // Flags are settled: the previous ALU op finished at least two cycles ago
        OP_JZ:  if (acc_zero)     pc_nxt = jmp_tgt;
        OP_JV:  if (acc_overflow) pc_nxt = jmp_tgt;
        OP_HLT: begin
          done   = 1'b1;
          pc_nxt = pc;
        end
        // NOP and the reserved opcode leave the ALU idle
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a synchronous ROM model.
module tb_alu_sequencer;

  localparam logic [3:0] NOP      = 4'hF;
  localparam logic [3:0] A_RESET  = 4'h0;
  localparam logic [3:0] A_REGA   = 4'h1;
  localparam logic [3:0] A_ADD    = 4'h2;
  localparam logic [3:0] A_OUT    = 4'h9;

  logic        clk;
  logic        s_reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        prog_en;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_data;
  logic        acc_zero;
  logic        acc_overflow;

  logic [11:0] rom [0:255];

  int vectors;
  int miscompares;

  alu_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NOP_OPCODE(4'hF)) dut (
    .clk          (clk),
    .s_reset      (s_reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .prog_en      (prog_en),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .alu_opcode   (alu_opcode),
    .alu_data     (alu_data),
    .acc_zero     (acc_zero),
    .acc_overflow (acc_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after prog_en
  always @(posedge clk) begin
    if (prog_en) prog_data <= rom[prog_addr];
  end

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset;
    s_reset = 1'b1;
    @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge where the DUT sits in FETCH of the first instruction
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    s_reset = 1'b1;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (prog_en !== 1'b0) begin miscompares++; $display("FAIL reset_prog_en got %b want 0", prog_en); end
    vectors++; if (prog_addr !== 8'h00) begin miscompares++; $display("FAIL reset_prog_addr got %h want 00", prog_addr); end
    vectors++; if (alu_opcode !== NOP) begin miscompares++; $display("FAIL reset_opcode got %h want %h", alu_opcode, NOP); end
    vectors++; if (alu_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", alu_data); end
    s_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_program;
    logic [3:0] exp_op;
    logic [7:0] exp_data;
    logic [7:0] exp_addr;
    logic       exp_done, exp_busy, exp_en;
    clear_rom();
    rom[0] = 12'h105; rom[1] = 12'h200; rom[2] = 12'h200; rom[3] = 12'h900; rom[4] = 12'hF00;
    do_reset();
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      exp_op   = NOP;
      exp_data = 8'h00;
      exp_done = (c == 15);
      exp_busy = (c <= 15);
      exp_en   = ((c % 3) == 1) && (c <= 13);
      exp_addr = 8'((c - 1) / 3);
      case (c)
        3:    begin exp_op = A_REGA; exp_data = 8'h05; end
        6, 9: exp_op = A_ADD;
        12:   exp_op = A_OUT;
        default: ;
      endcase
      vectors++; if (alu_opcode !== exp_op) begin miscompares++; $display("FAIL prog_opcode c=%0d got %h want %h", c, alu_opcode, exp_op); end
      vectors++; if (alu_data !== exp_data) begin miscompares++; $display("FAIL prog_data c=%0d got %h want %h", c, alu_data, exp_data); end
      vectors++; if (done !== exp_done) begin miscompares++; $display("FAIL prog_done c=%0d got %b want %b", c, done, exp_done); end
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL prog_busy c=%0d got %b want %b", c, busy, exp_busy); end
      vectors++; if (prog_en !== exp_en) begin miscompares++; $display("FAIL prog_en c=%0d got %b want %b", c, prog_en, exp_en); end
      if (exp_en) begin
        vectors++; if (prog_addr !== exp_addr) begin miscompares++; $display("FAIL prog_addr c=%0d got %h want %h", c, prog_addr, exp_addr); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jz(input logic z);
    logic [7:0] exp_tgt;
    clear_rom();
    rom[0] = 12'hA00; rom[1] = 12'hC05; rom[2] = 12'hF00; rom[5] = 12'hF00;
    exp_tgt  = z ? 8'h05 : 8'h02;
    acc_zero = z;
    do_reset();
    pulse_start();
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        vectors++; if (alu_opcode !== A_RESET) begin miscompares++; $display("FAIL jz_clr_opcode got %h want %h", alu_opcode, A_RESET); end
        vectors++; if (alu_data !== 8'h00) begin miscompares++; $display("FAIL jz_clr_data got %h want 00", alu_data); end
      end
      if (c == 7) begin
        vectors++; if (prog_en !== 1'b1) begin miscompares++; $display("FAIL jz_fetch_en z=%b got %b want 1", z, prog_en); end
        vectors++; if (prog_addr !== exp_tgt) begin miscompares++; $display("FAIL jz_target z=%b got %h want %h", z, prog_addr, exp_tgt); end
      end
      if (c == 9) begin
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL jz_done z=%b got %b want 1", z, done); end
      end
      if (c == 10) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL jz_idle z=%b got %b want 0", z, busy); end
      end
      @(negedge clk);
    end
    acc_zero = 1'b0;
  endtask

  task automatic test_jv(input logic v);
    logic [7:0] exp_tgt;
    clear_rom();
    rom[1] = 12'hE33; rom[3] = 12'hD08; rom[4] = 12'hF00; rom[8] = 12'hF00;
    exp_tgt      = v ? 8'h08 : 8'h04;
    acc_overflow = v;
    do_reset();
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      if (c == 3 || c == 6) begin
        vectors++; if (alu_opcode !== NOP) begin miscompares++; $display("FAIL jv_nop_opcode c=%0d got %h want %h", c, alu_opcode, NOP); end
        vectors++; if (alu_data !== 8'h00) begin miscompares++; $display("FAIL jv_nop_data c=%0d got %h want 00", c, alu_data); end
      end
      if (c == 13) begin
        vectors++; if (prog_addr !== exp_tgt) begin miscompares++; $display("FAIL jv_target v=%b got %h want %h", v, prog_addr, exp_tgt); end
      end
      if (c == 15) begin
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL jv_done v=%b got %b want 1", v, done); end
      end
      if (c == 16) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL jv_idle v=%b got %b want 0", v, busy); end
      end
      @(negedge clk);
    end
    acc_overflow = 1'b0;
  endtask

  task automatic test_wrap;
    clear_rom();
    rom[0] = 12'hBFF; rom[255] = 12'h000;
    do_reset();
    pulse_start();
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) begin
        vectors++; if (prog_en !== 1'b1) begin miscompares++; $display("FAIL wrap_fetch_en got %b want 1", prog_en); end
        vectors++; if (prog_addr !== 8'hFF) begin miscompares++; $display("FAIL wrap_jmp_ff got %h want ff", prog_addr); end
      end
      if (c == 6) begin
        vectors++; if (alu_opcode !== NOP) begin miscompares++; $display("FAIL wrap_nop got %h want %h", alu_opcode, NOP); end
      end
      if (c == 7) begin
        vectors++; if (prog_en !== 1'b1) begin miscompares++; $display("FAIL wrap_fetch0_en got %b want 1", prog_en); end
        vectors++; if (prog_addr !== 8'h00) begin miscompares++; $display("FAIL wrap_to_00 got %h want 00", prog_addr); end
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_midreset;
    clear_rom();
    rom[0] = 12'h105; rom[1] = 12'h200; rom[2] = 12'hF00;
    do_reset();
    pulse_start();
    repeat (5) @(negedge clk);
    vectors++; if (alu_opcode !== A_ADD) begin miscompares++; $display("FAIL mid_add_opcode got %h want %h", alu_opcode, A_ADD); end
    s_reset = 1'b1;
    @(negedge clk);
    s_reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", busy); end
    vectors++; if (alu_opcode !== NOP) begin miscompares++; $display("FAIL mid_opcode got %h want %h", alu_opcode, NOP); end
    vectors++; if (prog_addr !== 8'h00) begin miscompares++; $display("FAIL mid_pc got %h want 00", prog_addr); end
    vectors++; if (prog_en !== 1'b0) begin miscompares++; $display("FAIL mid_prog_en got %b want 0", prog_en); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done got %b want 0", done); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_stays_idle got %b want 0", busy); end
  endtask

  task automatic test_start_busy;
    int         n_done;
    logic [7:0] exp_addr;
    clear_rom();
    rom[0] = 12'h105; rom[1] = 12'h200; rom[2] = 12'h200; rom[3] = 12'h900; rom[4] = 12'hF00;
    n_done = 0;
    do_reset();
    pulse_start();
    for (int c = 1; c <= 25; c++) begin
      exp_addr = 8'((c - 1) / 3);
      if (done === 1'b1) n_done++;
      if (((c % 3) == 1) && (c <= 13)) begin
        vectors++; if (prog_addr !== exp_addr) begin miscompares++; $display("FAIL busy_pc_seq c=%0d got %h want %h", c, prog_addr, exp_addr); end
      end
      if (c >= 16) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_restart c=%0d got %b want 0", c, busy); end
      end
      start = (c == 5 || c == 10) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++; if (n_done != 1) begin miscompares++; $display("FAIL busy_done_count got %0d want 1", n_done); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    s_reset      = 1'b1;
    start        = 1'b0;
    acc_zero     = 1'b0;
    acc_overflow = 1'b0;
    clear_rom();
    test_reset();
    test_program();
    test_jz(1'b1);
    test_jz(1'b0);
    test_jv(1'b0);
    test_jv(1'b1);
    test_wrap();
    test_midreset();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
